// File: rtl/regfile_if.sv
// Register file bus: write, read, reserve and bulk-clear signals grouped for the
// decode/writeback stage.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NREAD  = 2
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                    we;
    logic [ADDR_W-1:0]       writeaddr;
    logic [DATA_W-1:0]       writedata;
    logic [NREAD*ADDR_W-1:0] readaddr;
    logic [NREAD*DATA_W-1:0] readdata;
    logic [NREAD-1:0]        readbusy;
    logic                    rsv;
    logic [ADDR_W-1:0]       rsvaddr;
    logic                    clr_start;
    logic                    clr_busy;
    logic                    wr_drop;

    modport master (
        output we, writeaddr, writedata, readaddr, rsv, rsvaddr, clr_start,
        input  readdata, readbusy, clr_busy, wr_drop
    );
    modport slave (
        input  we, writeaddr, writedata, readaddr, rsv, rsvaddr, clr_start,
        output readdata, readbusy, clr_busy, wr_drop
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with zero register, write bypass, busy scoreboard
// and a one-entry-per-cycle bulk-clear sequencer.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic     clk,
    input logic     rst,
    regfile_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    busy;
    logic [ADDR_W-1:0]   cnt;
    logic                clr_busy_q;
    logic                wr_drop_q;
    logic                wr_ok;
    logic                rsv_ok;

    assign wr_ok  = bus.we && (state == IDLE) &&
                    !((ZERO_REG != 0) && (bus.writeaddr == '0));
    assign rsv_ok = bus.rsv && (state == IDLE) &&
                    !((ZERO_REG != 0) && (bus.rsvaddr == '0));

    assign bus.clr_busy = clr_busy_q;
    assign bus.wr_drop  = wr_drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy       <= '0;
            state      <= IDLE;
            cnt        <= '0;
            clr_busy_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            wr_drop_q <= bus.we && (state == CLEAR);
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        mem[bus.writeaddr]  <= bus.writedata;
                        busy[bus.writeaddr] <= 1'b0;
                    end
                    // Reserve comes after the write so it wins on an address collision.
                    if (rsv_ok) busy[bus.rsvaddr] <= 1'b1;
                    if (bus.clr_start) begin
                        state      <= CLEAR;
                        cnt        <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[cnt]  <= '0;
                    busy[cnt] <= 1'b0;
                    cnt       <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state      <= IDLE;
                        clr_busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = bus.readaddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            bus.readdata[k*DATA_W +: DATA_W] = mem[ra];
            if ((ZERO_REG != 0) && (ra == '0))
                bus.readdata[k*DATA_W +: DATA_W] = '0;
            else if ((BYPASS != 0) && wr_ok && (bus.writeaddr == ra))
                bus.readdata[k*DATA_W +: DATA_W] = bus.writedata;
        end

        assign bus.readbusy[k] = busy[ra];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized checks of regfile_mp against a behavioural model.
module tb_regfile_mp;
    logic clk;
    logic rst;

    regfile_if #(.DATA_W(32), .DEPTH(32), .NREAD(2)) b ();
    regfile_if #(.DATA_W(32), .DEPTH(32), .NREAD(2)) bz ();

    regfile_mp #(.DATA_W(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1))
        u_dut (.clk(clk), .rst(rst), .bus(b));
    regfile_mp #(.DATA_W(32), .DEPTH(32), .NREAD(2), .ZERO_REG(0), .BYPASS(1))
        u_dz (.clk(clk), .rst(rst), .bus(bz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model state: contents, busy flags, and sweep progress.
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    bit          m_clr;
    int          m_pos;
    bit          m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_clr  = 1'b0;
        m_pos  = 0;
        m_drop = 1'b0;
    endtask

    task automatic model_update();
        m_drop = b.we && m_clr;
        if (!m_clr) begin
            if (b.we && b.writeaddr != 0) begin
                m_mem[b.writeaddr]  = b.writedata;
                m_busy[b.writeaddr] = 1'b0;
            end
            if (b.rsv && b.rsvaddr != 0) m_busy[b.rsvaddr] = 1'b1;
            if (b.clr_start) begin
                m_clr = 1'b1;
                m_pos = 0;
            end
        end else begin
            m_mem[m_pos]  = '0;
            m_busy[m_pos] = 1'b0;
            m_pos++;
            if (m_pos == 32) m_clr = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_rd(input int a);
        if (a == 0) return '0;
        if (b.we && !m_clr && a == int'(b.writeaddr)) return b.writedata;
        return m_mem[a];
    endfunction

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            int a;
            a = int'(b.readaddr[k*5 +: 5]);
            chk({tag, "_rd"}, b.readdata[k*32 +: 32], exp_rd(a));
            chk({tag, "_busy"}, 32'(b.readbusy[k]), 32'(m_busy[a]));
        end
        chk({tag, "_clrbusy"}, 32'(b.clr_busy), 32'(m_clr));
        chk({tag, "_wrdrop"}, 32'(b.wr_drop), 32'(m_drop));
    endtask

    task automatic set_idle();
        b.we = 0; b.rsv = 0; b.clr_start = 0;
        bz.we = 0; bz.rsv = 0; bz.clr_start = 0;
    endtask

    // Inputs are set at posedge+1; check at +2, then advance one edge.
    task automatic step(input string tag);
        #1 check_outputs(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            b.readaddr = {5'(31 - a), 5'(a)};
            #1;
            chk({tag, "_rd0"}, b.readdata[31:0], 32'h0);
            chk({tag, "_rd1"}, b.readdata[63:32], 32'h0);
            chk({tag, "_bz"}, 32'(b.readbusy), 32'h0);
        end
    endtask

    initial begin
        int nbusy, ndrop, guard;
        rst = 1'b1;
        b.we = 0; b.writeaddr = '0; b.writedata = '0; b.readaddr = '0;
        b.rsv = 0; b.rsvaddr = '0; b.clr_start = 0;
        bz.we = 0; bz.writeaddr = '0; bz.writedata = '0; bz.readaddr = '0;
        bz.rsv = 0; bz.rsvaddr = '0; bz.clr_start = 0;
        model_reset();
        @(posedge clk); #1;
        chk("rst_clrbusy", 32'(b.clr_busy), 32'h0);
        chk("rst_wrdrop", 32'(b.wr_drop), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        read_all_zero("reset");

        // Bypass then registered read of r5.
        b.we = 1; b.writeaddr = 5; b.writedata = 32'hDEADBEEF; b.readaddr = {5'd0, 5'd5};
        #1 chk("bypass", b.readdata[31:0], 32'hDEADBEEF);
        step("wr5");
        set_idle();
        #1 chk("r5_held", b.readdata[31:0], 32'hDEADBEEF);

        // Zero-register write on both flavours.
        b.we = 1; b.writeaddr = 0; b.writedata = 32'h1234; b.readaddr = '0;
        bz.we = 1; bz.writeaddr = 0; bz.writedata = 32'h1234; bz.readaddr = '0;
        step("wr0");
        set_idle();
        #1;
        chk("r0_zero", b.readdata[31:0], 32'h0);
        chk("r0_nodrop", 32'(b.wr_drop), 32'h0);
        chk("r0_nozero", bz.readdata[31:0], 32'h1234);

        // Scoreboard: reserve, write-clears, reserve-wins.
        b.rsv = 1; b.rsvaddr = 7; b.readaddr = {5'd0, 5'd7};
        step("rsv7");
        set_idle();
        #1 chk("busy7_set", 32'(b.readbusy[0]), 32'h1);
        b.we = 1; b.writeaddr = 7; b.writedata = 32'h55;
        #1 chk("busy7_unmasked", 32'(b.readbusy[0]), 32'h1);
        step("wr7");
        set_idle();
        #1 chk("busy7_clr", 32'(b.readbusy[0]), 32'h0);
        b.rsv = 1; b.rsvaddr = 9; b.we = 1; b.writeaddr = 9; b.writedata = 32'h66;
        b.readaddr = {5'd0, 5'd9};
        step("rsvwr9");
        set_idle();
        #1;
        chk("r9_data", b.readdata[31:0], 32'h66);
        chk("r9_busy", 32'(b.readbusy[0]), 32'h1);

        // Load r1..r31 with index, sweep, drop a write at sweep cycle 10.
        for (int i = 1; i < 32; i++) begin
            b.we = 1; b.writeaddr = 5'(i); b.writedata = 32'(i);
            b.readaddr = {5'(i), 5'($urandom_range(31))};
            step("load");
        end
        set_idle();
        b.clr_start = 1;
        step("clrstart");
        b.clr_start = 0;
        nbusy = 0; ndrop = 0;
        for (int i = 0; i < 40; i++) begin
            if (b.clr_busy) nbusy++;
            if (b.wr_drop) ndrop++;
            b.we = (m_clr && m_pos == 10);
            b.writeaddr = 3; b.writedata = 32'hBAD;
            b.readaddr = {5'($urandom_range(31)), 5'($urandom_range(31))};
            step("sweep");
        end
        chk("sweep_len", 32'(nbusy), 32'd32);
        chk("sweep_drops", 32'(ndrop), 32'd1);
        read_all_zero("swept");

        // Reset mid-sweep at cycle 12.
        for (int i = 1; i < 32; i++) begin
            b.we = 1; b.writeaddr = 5'(i); b.writedata = 32'hA000 + 32'(i);
            step("reload");
        end
        set_idle();
        b.clr_start = 1;
        step("clrstart2");
        b.clr_start = 0;
        guard = 0;
        while (m_pos != 12 && guard < 40) begin
            step("sweep2");
            guard++;
        end
        chk("sweep2_reached", 32'(m_pos), 32'd12);
        rst = 1'b1;
        model_reset();
        #1 chk("abort_clrbusy", 32'(b.clr_busy), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        read_all_zero("abort");
        b.clr_start = 1;
        step("clrstart3");
        b.clr_start = 0;
        chk("restart", 32'(b.clr_busy), 32'h1);
        guard = 0;
        while (m_clr && guard < 40) begin
            step("sweep3");
            guard++;
        end
        chk("sweep3_done", 32'(b.clr_busy), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            b.we        = ($urandom_range(1) == 1);
            b.writeaddr = 5'($urandom_range(31));
            b.writedata = $urandom;
            b.rsv       = ($urandom_range(2) == 0);
            b.rsvaddr   = ($urandom_range(3) == 0) ? b.writeaddr : 5'($urandom_range(31));
            b.clr_start = ($urandom_range(79) == 0);
            b.readaddr  = ($urandom_range(3) == 0) ? {5'($urandom_range(31)), b.writeaddr}
                                                   : 10'($urandom_range(1023));
            step("rand");
        end
        set_idle();
        step("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
